// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: lit-polarity (1 = lit) segment
// patterns in gfedcba order, segment index bounds and the scan FSM state type.
package seg_pkg;

  localparam int unsigned SegA = 0;
  localparam int unsigned SegG = 6;

  localparam logic [6:0] SegPat0    = 7'b0111111;
  localparam logic [6:0] SegPat1    = 7'b0000110;
  localparam logic [6:0] SegPat2    = 7'b1011011;
  localparam logic [6:0] SegPat3    = 7'b1001111;
  localparam logic [6:0] SegPat4    = 7'b1100110;
  localparam logic [6:0] SegPat5    = 7'b1101101;
  localparam logic [6:0] SegPat6    = 7'b1111101;
  localparam logic [6:0] SegPat7    = 7'b0000111;
  localparam logic [6:0] SegPat7Alt = 7'b0100111;
  localparam logic [6:0] SegPat8    = 7'b1111111;
  localparam logic [6:0] SegPat9    = 7'b1101111;
  localparam logic [6:0] SegPatA    = 7'b1110111;
  localparam logic [6:0] SegPatB    = 7'b1111100;
  localparam logic [6:0] SegPatC    = 7'b0111001;
  localparam logic [6:0] SegPatD    = 7'b1011110;
  localparam logic [6:0] SegPatE    = 7'b1111001;
  localparam logic [6:0] SegPatF    = 7'b1110001;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } seg_state_e;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display-side bundle of the scan decoder: raw scanned lines in, decoded frame out.
interface seg_scan_decoder_if #(
  parameter int unsigned NUM_DIG = 2
);
  logic [6:0]           iSEG;
  logic [NUM_DIG-1:0]   iDIG_SEL;
  logic [4*NUM_DIG-1:0] oNUM;
  logic                 oVALID;
  logic                 oERR;

  modport master (
    output iSEG,
    output iDIG_SEL,
    input  oNUM,
    input  oVALID,
    input  oERR
  );

  modport slave (
    input  iSEG,
    input  iDIG_SEL,
    output oNUM,
    output oVALID,
    output oERR
  );
endinterface

// File: rtl/seg_pattern_dec.sv
// Combinational lit-polarity segment pattern to BCD decoder with pattern-error flag.
// Defining SEG_DEC_HEX_EN adds the A-F glyphs as valid codes.
module seg_pattern_dec
  import seg_pkg::*;
(
  input  logic [SegG:SegA] lit,
  output logic [3:0]       val,
  output logic             err
);

  always_comb begin
    val = 4'hF;
    err = 1'b0;
    case (lit)
      SegPat0:             val = 4'h0;
      SegPat1:             val = 4'h1;
      SegPat2:             val = 4'h2;
      SegPat3:             val = 4'h3;
      SegPat4:             val = 4'h4;
      SegPat5:             val = 4'h5;
      SegPat6:             val = 4'h6;
      SegPat7, SegPat7Alt: val = 4'h7;
      SegPat8:             val = 4'h8;
      SegPat9:             val = 4'h9;
`ifdef SEG_DEC_HEX_EN
      SegPatA:             val = 4'hA;
      SegPatB:             val = 4'hB;
      SegPatC:             val = 4'hC;
      SegPatD:             val = 4'hD;
      SegPatE:             val = 4'hE;
      SegPatF:             val = 4'hF;
`endif
      default:             err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed seven-segment display: synchronises the scanned lines,
// filters scan glitches, and emits one decoded frame per complete scan of all digits.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIG        = 2,
  parameter int unsigned STABLE_CYC     = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seg_scan_decoder_if.slave bus
);

  localparam int unsigned WordW = NUM_DIG + 7;
  localparam int unsigned CntW  = $clog2(STABLE_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC - 1);
  // Accept fires on the matching sample that takes the counter to STABLE_CYC-1.
  localparam logic [CntW-1:0] CntAcc = CntW'(STABLE_CYC - 2);

  logic [WordW-1:0]     sync1_q, sync2_q, sample;
  logic [WordW-1:0]     ref_q, ref_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  seg_state_e           state_q, state_d;
  logic                 match, accept, acc_ok;
  logic [NUM_DIG-1:0]   ref_sel, wr;
  logic [6:0]           ref_seg;
  logic [3:0]           dec_val;
  logic                 dec_err;
  logic [4*NUM_DIG-1:0] buf_q, buf_d, num_q, num_d;
  logic [NUM_DIG-1:0]   seen_q, seen_d;
  logic                 err_acc_q, err_acc_d, err_q, err_d, valid_q, valid_d;
  logic                 seen_full;

  // Input synchroniser; segments are flipped afterwards so the core always sees 1 = lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.iDIG_SEL, bus.iSEG};
      sync2_q <= sync1_q;
    end
  end

  assign sample = SEG_ACTIVE_LOW ? {sync2_q[WordW-1:7], ~sync2_q[6:0]} : sync2_q;
  assign match  = (sample == ref_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ref_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        ref_d   = sample;
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (match) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntAcc) state_d = StHold;
        end else begin
          ref_d = sample;
          cnt_d = '0;
        end
      end
      StHold: begin
        if (!match) begin
          ref_d   = sample;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    accept = (state_q == StSettle) && match && (cnt_q == CntAcc);
  end

  assign ref_sel = ref_q[WordW-1:7];
  assign ref_seg = ref_q[6:0];

  seg_pattern_dec u_dec (
    .lit (ref_seg),
    .val (dec_val),
    .err (dec_err)
  );

  // A zero or multi-hot select is a scan transition, not a digit, so it is dropped.
  assign acc_ok    = accept && $onehot(ref_sel);
  assign wr        = acc_ok ? ref_sel : '0;
  assign seen_full = &seen_q;

  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < int'(NUM_DIG); k++) begin
      if (wr[k]) buf_d[4*k +: 4] = dec_val;
    end
    // Closing a frame clears the accumulators first so a same-cycle accept starts the next one.
    seen_d    = (seen_full ? '0 : seen_q) | wr;
    err_acc_d = (seen_full ? 1'b0 : err_acc_q) | (acc_ok & dec_err);
    valid_d   = seen_full;
    num_d     = seen_full ? buf_q : num_q;
    err_d     = seen_full ? err_acc_q : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q     <= '0;
      seen_q    <= '0;
      err_acc_q <= 1'b0;
      valid_q   <= 1'b0;
      num_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      seen_q    <= seen_d;
      err_acc_q <= err_acc_d;
      valid_q   <= valid_d;
      num_q     <= num_d;
      err_q     <= err_d;
    end
  end

  assign bus.oNUM   = num_q;
  assign bus.oVALID = valid_q;
  assign bus.oERR   = err_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed seven-segment display interface: samples scanned segment and digit-select lines and recovers the displayed BCD digits.
- Used for display loop-back checking and for reading boards that present their counters only on a seven-segment display.
- Filters scan glitches with a stability counter and assembles one frame per full scan.
- Emits a one-cycle frame-valid pulse with a per-frame error flag.

Parameters:
- NUM_DIG, 2, number of scanned digits (1..8).
- STABLE_CYC, 16, consecutive identical samples required before a pattern is accepted (>=2).
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- iSEG  in  7  segment lines; bit0=a … bit6=g; asynchronous to clk.
- iDIG_SEL  in  NUM_DIG  digit select, one-hot active-high; bit k = digit k; asynchronous.
- oNUM  out  4*NUM_DIG  decoded digits; digit k at [4k+3:4k]; updated once per frame.
- oVALID  out  1  one-cycle pulse when oNUM updates.
- oERR  out  1  set with oVALID when any digit in that frame was an undecodable pattern; holds until the next oVALID.

Behaviour:
- Input stage: 2-flop synchroniser on {iDIG_SEL, iSEG}; sampled word = sync output.
- If SEG_ACTIVE_LOW=1, segments are inverted internally so that 1 = lit.
- FSM states:
  - IDLE: after reset. Load the sampled word into the reference register, clear the counter, go to SETTLE.
  - SETTLE: if sample equals the reference, increment the counter; otherwise reload the reference, clear the counter, stay in SETTLE. When the counter reaches STABLE_CYC-1 with a matching sample, ACCEPT on that cycle and go to HOLD.
  - HOLD: stay while sample equals the reference. The same pattern is never accepted twice. On any change, reload the reference, clear the counter, go to SETTLE.
- ACCEPT:
  - If the reference dig_sel is exactly one-hot at index k: decode the segments, write digit_buf[k], set seen[k], and OR the pattern error into err_acc.
  - Zero or multi-hot dig_sel: accept is ignored; no state change apart from the FSM.
- Decode, lit-polarity gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - 7 also matches 0100111.
  - Any other pattern → value 4'hF and pattern error.
- A digit re-accepted before the frame completes overwrites its value; the latest value wins; seen stays set.
- Frame completion: the cycle after seen becomes all-ones:
  - oNUM <= digit_buf, oERR <= err_acc, oVALID=1.
  - seen and err_acc are cleared in the same cycle.
  - An accept in that same cycle belongs to the next frame.
- Latency:
  - Input change to ACCEPT = STABLE_CYC+2 clk, with the input held stable throughout.
  - ACCEPT of the last missing digit to oVALID = 1 clk.
- Reset (any time, including mid-frame):
  - oNUM=0, oVALID=0, oERR=0.
  - seen=0, err_acc=0, digit_buf=0, counter=0, FSM=IDLE.
  - Synchroniser flops cleared; no frame is emitted from pre-reset data.
- Counter width: $clog2(STABLE_CYC); saturates, never wraps.

Optional Feature:
- Macro: SEG_DEC_HEX_EN.
- Defined: also decode A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001 to 4'hA–4'hF without error. Only unmatched patterns error; they still return 4'hF.
- Undefined: these patterns are errors and decode to 4'hF.

Decomposition:
- Package seg_pkg:
  - Segment pattern constants for 0–9 and A–F.
  - FSM state enum {IDLE, SETTLE, HOLD}.
  - Segment-index constants.
- One sub-module: seg_pattern_dec, combinational 7-bit lit-polarity pattern → {err, val[3:0]}, containing the SEG_DEC_HEX_EN logic.
- The top-level holds the synchroniser, FSM, buffers and frame logic.

Test Plan:
- Basic frame:
  - Stimulus (NUM_DIG=2, STABLE_CYC=16, active-low): dig_sel=01 with iSEG=0110000 (3) for 40 clk, then dig_sel=10 with iSEG=0010010 (5) for 40 clk.
  - Response: one oVALID pulse, oNUM=8'h53, oERR=0.
  - Pulse is 19 clk after the second change (STABLE_CYC+2 to ACCEPT, +1).
- Glitch filter:
  - Stimulus: digit-0 pattern toggles every 5 clk for 100 clk, then holds 3.
  - Response: no accept during the toggling; digit 0 is captured only after 18 stable clk.
- Invalid pattern:
  - Stimulus: digit 1 shows iSEG=1111110, with SEG_DEC_HEX_EN undefined.
  - Response: oNUM[7:4]=4'hF, oERR=1 on that frame's oVALID; the next clean frame gives oERR=0.
- Overwrite and bad select:
  - Stimulus: digit 0 shows 1, then digit 0 shows 7, then dig_sel=11 for 40 clk, then digit 1 shows 2.
  - Response: the dig_sel=11 interval is ignored; the single frame reads oNUM=8'h27.
- Reset mid-frame:
  - Stimulus: digit 0 accepted, rst high for 1 clk, then only digit 1 is scanned.
  - Response: oNUM=0, oVALID=0 after reset; no frame is emitted until digit 0 is scanned again.
- Hex decode:
  - Stimulus: with SEG_DEC_HEX_EN defined, scan C (1000110 active-low) on digit 0 and E on digit 1.
  - Response: oNUM=8'hEC, oERR=0.
